// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB configuration scheduler.
package sccb_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    DECODE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    READY,
    H_ISSUE,
    H_WAIT
  } state_t;

  // Init-table markers: end of table, and "pause before next entry".
  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  // Pause length in clock cycles for one ROM_DELAY entry.
  function automatic int unsigned delay_cycles(input int unsigned clk_hz,
                                               input int unsigned delay_ms);
    return clk_hz / 1000 * delay_ms;
  endfunction

endpackage

// File: rtl/sccb_delay_timer.sv
// Loadable down-counter with a zero flag; used for the init-table pauses.
module sccb_delay_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sccb_cfg_scheduler.sv
// Walks the OV7670 init ROM into the SCCB write engine, then arbitrates
// runtime host register writes onto the same master.
module sccb_cfg_scheduler
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned DELAY_MS = 10,
  parameter int unsigned ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_reg_addr,
  output logic [7:0]        m_reg_data,
  input  logic              m_done,
  input  logic              host_req,
  input  logic [7:0]        host_reg_addr,
  input  logic [7:0]        host_reg_data,
  output logic              host_ack,
  output logic              busy,
  output logic              init_done,
  output logic [7:0]        cfg_count
);

  localparam int unsigned DELAY_CYC = delay_cycles(CLK_HZ, DELAY_MS);
  localparam int unsigned TW        = (DELAY_CYC < 1) ? 1 : $clog2(DELAY_CYC + 1);
  localparam logic [TW-1:0]     DLY_LOAD = TW'((DELAY_CYC < 1) ? 0 : DELAY_CYC - 1);
  localparam logic [ROM_AW-1:0] IDX_LAST = {ROM_AW{1'b1}};

  state_t            state, state_nxt;
  logic [ROM_AW-1:0] idx, idx_nxt;
  logic [7:0]        cnt_nxt, addr_nxt, data_nxt;
  logic              adv;
  logic              tmr_load, tmr_dec, tmr_zero;

  sccb_delay_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (DLY_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State and datapath registers; reset leaves every output at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      cfg_count  <= '0;
      m_reg_addr <= '0;
      m_reg_data <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cfg_count  <= cnt_nxt;
      m_reg_addr <= addr_nxt;
      m_reg_data <= data_nxt;
    end
  end

  // Next-state logic; 'adv' moves to the next ROM entry or stops at the last index.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cfg_count;
    addr_nxt  = m_reg_addr;
    data_nxt  = m_reg_data;
    adv       = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = FETCH;
        end
      end
      FETCH:    state_nxt = WAIT_ROM;
      WAIT_ROM: state_nxt = DECODE;
      DECODE: begin
        if (rom_data == ROM_END) begin
          state_nxt = READY;
        end else if (rom_data == ROM_DELAY) begin
          tmr_load  = 1'b1;
          state_nxt = DELAY;
        end else begin
          addr_nxt  = rom_data[15:8];
          data_nxt  = rom_data[7:0];
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (m_done) begin
          if (cfg_count != 8'hFF) cnt_nxt = cfg_count + 8'd1;
          adv = 1'b1;
        end
      end
      DELAY: begin
        if (tmr_zero) adv = 1'b1;
        else          tmr_dec = 1'b1;
      end
      READY: begin
        if (start) begin
          idx_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = FETCH;
        end else if (host_req) begin
          addr_nxt  = host_reg_addr;
          data_nxt  = host_reg_data;
          state_nxt = H_ISSUE;
        end
      end
      H_ISSUE: begin
        if (m_ready) state_nxt = H_WAIT;
      end
      H_WAIT: begin
        if (m_done) state_nxt = READY;
      end
      default: state_nxt = IDLE;
    endcase
    if (adv) begin
      if (idx == IDX_LAST) begin
        state_nxt = READY;
      end else begin
        idx_nxt   = idx + 1'b1;
        state_nxt = FETCH;
      end
    end
  end

  assign rom_addr  = idx;
  assign m_valid   = (state == ISSUE) || (state == H_ISSUE);
  assign busy      = (state != IDLE) && (state != READY);
  assign init_done = (state == READY);
  assign host_ack  = (state == H_WAIT) && m_done;

endmodule

// File: tb/tb_sccb_cfg_scheduler.sv
// Directed bench for sccb_cfg_scheduler with a small SCCB master and ROM model.
module tb_sccb_cfg_scheduler;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned DELAY_MS = 5;
  localparam int unsigned ROM_AW   = 2;
  localparam int unsigned DLY      = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data = 16'h0000;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [7:0]        m_reg_addr, m_reg_data;
  logic              m_done;
  logic              done_mdl = 1'b0;
  logic              done_force = 1'b0;
  logic              host_req = 1'b0;
  logic [7:0]        host_reg_addr = 8'h00, host_reg_data = 8'h00;
  logic              host_ack, busy, init_done;
  logic [7:0]        cfg_count;

  logic [15:0] rom [4];
  logic [15:0] wq [$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stall_until = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  int a1_cyc = 0;
  int v_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_addr = 8'h00, prev_data = 8'h00;

  assign m_done = done_mdl | done_force;

  sccb_cfg_scheduler #(
    .CLK_HZ   (CLK_HZ),
    .DELAY_MS (DELAY_MS),
    .ROM_AW   (ROM_AW)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_reg_addr    (m_reg_addr),
    .m_reg_data    (m_reg_data),
    .m_done        (m_done),
    .host_req      (host_req),
    .host_reg_addr (host_reg_addr),
    .host_reg_data (host_reg_data),
    .host_ack      (host_ack),
    .busy          (busy),
    .init_done     (init_done),
    .cfg_count     (cfg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Registered ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Master model: ready two cycles into a request, done ten cycles after accept.
  always @(posedge clk) begin
    #1;
    done_mdl = 1'b0;
    if (!rst_n) begin
      m_ready = 1'b0; done_cnt = 0; vld_cnt = 0;
    end else if (m_ready) begin
      m_ready = 1'b0; done_cnt = 10; vld_cnt = 0;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) done_mdl = 1'b1;
    end else if (m_valid && cyc >= stall_until) begin
      vld_cnt++;
      if (vld_cnt >= 2) m_ready = 1'b1;
    end
  end

  // Write log, request-stability checks and cycle counters.
  always @(negedge clk) begin
    if (m_valid && prev_valid) begin
      chk("stable_addr", {24'd0, m_reg_addr}, {24'd0, prev_addr});
      chk("stable_data", {24'd0, m_reg_data}, {24'd0, prev_data});
    end
    prev_valid = m_valid;
    prev_addr  = m_reg_addr;
    prev_data  = m_reg_data;
    if (m_valid && m_ready) wq.push_back({m_reg_addr, m_reg_data});
    if (m_valid) v_cyc++;
    if (busy && rom_addr == 2'd1) a1_cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    chk(tag, {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_ack_and_drop(input string tag);
    for (int i = 0; i < 3000 && !host_ack; i++) @(negedge clk);
    chk(tag, {31'd0, host_ack}, 32'd1);
    host_req = 1'b0;
  endtask

  initial begin
    int base, a1_base, v_base;
    logic [7:0] cnt_snap;

    // Reset state
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_cfg_count", {24'd0, cfg_count}, 32'd0);
    chk("rst_rom_addr", {30'd0, rom_addr}, 32'd0);
    chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
    chk("rst_m_reg", {16'd0, m_reg_addr, m_reg_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 1: basic boot with a delay marker
    base = wq.size(); a1_base = a1_cyc;
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_ready("t1_ready");
    chk("t1_nwrites", wq.size() - base, 32'd2);
    if (wq.size() >= base + 2) begin
      chk("t1_w0", {16'd0, wq[base]}, 32'h1280);
      chk("t1_w1", {16'd0, wq[base+1]}, 32'h1214);
    end
    chk("t1_idx1_cycles", a1_cyc - a1_base, 3 + DLY);
    chk("t1_cfg_count", {24'd0, cfg_count}, 32'd2);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);

    // 2: master stalls ready for 20 cycles
    rom[0] = 16'hABCD; rom[1] = 16'hFFFF;
    base = wq.size(); v_base = v_cyc;
    pulse_start();
    for (int i = 0; i < 100 && !m_valid; i++) @(negedge clk);
    chk("t2_valid_seen", {31'd0, m_valid}, 32'd1);
    stall_until = cyc + 20;
    wait_ready("t2_ready");
    chk("t2_nwrites", wq.size() - base, 32'd1);
    if (wq.size() >= base + 1) chk("t2_w0", {16'd0, wq[base]}, 32'hABCD);
    chk("t2_valid_long", {31'd0, (v_cyc - v_base) >= 20}, 32'd1);
    chk("t2_cfg_count", {24'd0, cfg_count}, 32'd1);

    // 3: host request during boot waits for READY
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    base = wq.size();
    pulse_start();
    repeat (3) @(negedge clk);
    host_reg_addr = 8'h13; host_reg_data = 8'hE7; host_req = 1'b1;
    wait_ready("t3_ready");
    chk("t3_no_early_host", wq.size() - base, 32'd2);
    cnt_snap = cfg_count;
    wait_ack_and_drop("t3_ack");
    @(negedge clk);
    chk("t3_ack_single", {31'd0, host_ack}, 32'd0);
    chk("t3_back_ready", {31'd0, init_done}, 32'd1);
    chk("t3_nwrites", wq.size() - base, 32'd3);
    if (wq.size() >= base + 3) chk("t3_host_w", {16'd0, wq[base+2]}, 32'h13E7);
    chk("t3_cfg_unchanged", {24'd0, cfg_count}, {24'd0, cnt_snap});
    repeat (4) @(negedge clk);
    chk("t3_no_repeat", wq.size() - base, 32'd3);

    // 4: start and host_req together in READY
    base = wq.size();
    @(negedge clk);
    host_reg_addr = 8'h13; host_reg_data = 8'h55;
    start = 1'b1; host_req = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("t4_restart_busy", {31'd0, busy}, 32'd1);
    chk("t4_init_cleared", {31'd0, init_done}, 32'd0);
    chk("t4_cnt_cleared", {24'd0, cfg_count}, 32'd0);
    chk("t4_idx0", {30'd0, rom_addr}, 32'd0);
    wait_ready("t4_ready");
    chk("t4_boot_writes", wq.size() - base, 32'd2);
    wait_ack_and_drop("t4_ack");
    @(negedge clk);
    chk("t4_nwrites", wq.size() - base, 32'd3);
    if (wq.size() >= base + 3) chk("t4_host_w", {16'd0, wq[base+2]}, 32'h1355);
    chk("t4_cfg_count", {24'd0, cfg_count}, 32'd2);

    // 5: table without end marker stops at the last index
    rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'h0303; rom[3] = 16'h0404;
    base = wq.size();
    pulse_start();
    wait_ready("t5_ready");
    chk("t5_nwrites", wq.size() - base, 32'd4);
    if (wq.size() >= base + 4) begin
      chk("t5_w0", {16'd0, wq[base]}, 32'h0101);
      chk("t5_w3", {16'd0, wq[base+3]}, 32'h0404);
    end
    chk("t5_cfg_count", {24'd0, cfg_count}, 32'd4);
    repeat (5) @(negedge clk);
    chk("t5_no_wrap", {30'd0, rom_addr}, 32'd3);
    chk("t5_stays_ready", {31'd0, init_done}, 32'd1);

    // 6: reset while waiting for done
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    base = wq.size();
    pulse_start();
    for (int i = 0; i < 100 && wq.size() == base; i++) @(negedge clk);
    chk("t6_accepted", wq.size() - base, 32'd1);
    @(posedge clk);
    #2;
    chk("t6_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_cnt", {24'd0, cfg_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk) done_force = 1'b1;
    @(negedge clk) done_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    chk("t6_idle_init", {31'd0, init_done}, 32'd0);
    chk("t6_idle_cnt", {24'd0, cfg_count}, 32'd0);
    chk("t6_idle_valid", {31'd0, m_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
